pt_steer_section: RTL and testbench
===================================

# pt_steer_section

Parametrised product-term steering and macrocell register stage for N macrocells of the ATF CPLD model. It extends the single-macrocell PT5 routing to cover both PT5 and PT4. PT5 steers to the sum term, async set, or output enable; PT4 steers to the sum term or async reset. The steered terms feed a per-macrocell D/T/bypass register clocked from the global clock. It sits between the product-term array and the I/O output-enable and feedback logic.

## Interface
Parameters:
- N_MC, default 4: number of macrocells (≥1).

Ports:
- clk  in  1  global clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pt5_mux  in  N_MC  per-macrocell; 0: PT5 to sum term, 1: PT5 to function path.
- pt5_func_mux  in  N_MC  1: PT5 drives OE, 0: PT5 drives async set; only meaningful when pt5_mux=1.
- pt4_mux  in  N_MC  0: PT4 to sum term, 1: PT4 drives async reset.
- reg_mode  in  2·N_MC  per macrocell [2i+1:2i]; 00 D, 01 T, 10 combinational bypass, 11 treated as D.
- ce  in  N_MC  per-macrocell clock enable.
- sum_v  in  N_MC  OR of the macrocell's other product terms (PT1–PT3).
- pt5_v, pt4_v  in  N_MC  product-term values.
- sti5_v, sti4_v  out  N_MC  steered sum-term contributions.
- oe_v  out  N_MC  output enable.
- q_v  out  N_MC  macrocell output.

## Operation
Per macrocell i (independent; no cross-macrocell interaction):
- sti5 = pt5_v & ~pt5_mux. sti4 = pt4_v & ~pt4_mux. Unselected routes drive 0.
- as = pt5_v & pt5_mux & ~pt5_func_mux. ar = pt4_v & pt4_mux.
- oe = (pt5_mux & pt5_func_mux) ? pt5_v : 1. OE is the VCC default when not routed.
- d = sum_v | sti5 | sti4.
- State bit s, updated on each clk edge:
  - rst → 0.
  - else ar → 0 (reset beats set).
  - else as → 1.
  - else ce=0 → hold.
  - else D/11: s ← d; T: s ← s ^ d; bypass: s ← d (tracked, so a mode switch out of bypass starts from a defined value).
- Output:
  - bypass mode: q = d.
  - registered modes: q = ar ? 0 : as ? 1 : s. The set/reset override is combinational, modelling the device's asynchronous set/reset within the one-clock model.
  - rst does not mask the override; during reset, q = ar?0:as?1:0.
- Configuration inputs are combinational on steering. Mode changes affect the next edge's update rule.

## Timing
- Steering outputs (sti5, sti4, oe) and the set/reset override on q: zero latency, combinational.
- Registered path: d sampled at edge k appears on q after edge k (1-cycle latency).
- Reset: s=0 after the first rst edge. With all PTs low and registered mode, q=0, sti*=0, oe=1.
- rst high mid-operation clears s on that edge regardless of ce, as, ar, or mode.
- ar and as both high: q=0 immediately, s=0 at edge.
- as released: q returns to s on the same cycle. s already holds 1 if as was high across an edge.
- T mode with d=1, ce=1: q toggles every cycle.

## Structure
- Shared package atf_mc_pkg: reg_mode constants MODE_D=2'b00, MODE_T=2'b01, MODE_BYP=2'b10. The package is shared with the future I/O block.
- Sub-module mc_reg: one-bit register holding s, with rst/ar/as/ce/mode priority and the q override. It is instantiated N_MC times in a generate loop.
- Steering logic stays inline in the top.
- Expected size: ~180 lines.

## Test plan
- N_MC=4, all configuration 0, pt5_v=4'b1010, sum_v=0 → sti5_v=4'b1010, oe_v=4'hF; q_v=4'b1010 one cycle later (D, ce=1).
- pt5_mux=1, pt5_func_mux=1, pt5_v toggling 0/1 → oe_v follows pt5_v same cycle; sti5_v=0; q_v unaffected by pt5_v.
- T mode, ce=1, sum_v=1, rst deasserted after reset → q_v sequence 1,0,1,0 on successive edges; ce=0 for 2 cycles holds the value.
- pt4_mux=1, pt5_mux=1, pt5_func_mux=0, pt4_v=pt5_v=1 with s=1 → q=0 immediately, s=0 after the edge. Drop pt4_v → q=1 same cycle.
- rst asserted for 1 cycle mid T-toggle with ce=1 → s=0 after the edge; toggling resumes from 0 (q=1 on the next edge).
- Bypass mode, sum_v changes between edges → q follows combinationally. Switch to D → q holds the last sampled d until the next edge.

Source files
------------

// File: rtl/atf_mc_pkg.sv
// Shared definitions for the ATF CPLD macrocell model.
// Purpose: register-mode encodings and a small decode helper. The macrocell
//          register stage uses this package, and the I/O block will use it too.
// Ports:   none (package).
package atf_mc_pkg;

  // Encoding of the per-macrocell reg_mode field. The fourth code, 2'b11,
  // is not listed here because the register treats it as D.
  localparam logic [1:0] MODE_D   = 2'b00;
  localparam logic [1:0] MODE_T   = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;

  // Returns 1 when the macrocell output bypasses the register.
  function automatic logic mode_is_bypass(input logic [1:0] mode);
    return (mode == MODE_BYP);
  endfunction

endpackage

// File: rtl/pt_steer_section_mc_reg.sv
// One-bit macrocell register stage.
// Purpose: holds the state bit s and applies the update priority
//          rst > ar > as > ce, using either the D/T rule or the bypass rule.
//          It also drives q, with the set/reset override applied
//          combinationally.
// Ports:
//   clk   in  global clock, rising edge
//   rst   in  synchronous active-high reset
//   ar    in  asynchronous-reset product term (already steered)
//   as    in  asynchronous-set product term (already steered)
//   ce    in  clock enable
//   mode  in  reg_mode field (00 D, 01 T, 10 bypass, 11 D)
//   d     in  sum-term input
//   q     out macrocell output
module mc_reg
  import atf_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ar,
  input  logic       as,
  input  logic       ce,
  input  logic [1:0] mode,
  input  logic       d,
  output logic       q
);

  logic s;

  // State update. Reset beats set. In bypass mode s still follows d, so
  // leaving bypass starts from the last sampled d and not from a stale value.
  always_ff @(posedge clk) begin
    if (rst)
      s <= 1'b0;
    else if (ar)
      s <= 1'b0;
    else if (as)
      s <= 1'b1;
    else if (ce) begin
      if (mode == MODE_T)
        s <= s ^ d;
      else
        s <= d;
    end
  end

  // Output. Within the one-clock model, the set/reset override stands in
  // for the device's asynchronous set/reset. rst does not mask it.
  always_comb begin
    if (mode_is_bypass(mode))
      q = d;
    else if (ar)
      q = 1'b0;
    else if (as)
      q = 1'b1;
    else
      q = s;
  end

endmodule

// File: rtl/pt_steer_section.sv
// Product-term steering and macrocell register stage for N_MC macrocells.
// Purpose: routes PT5 to the sum term, async set or OE, and routes PT4 to the
//          sum term or async reset. The steered terms then feed one mc_reg
//          per macrocell.
// Ports:
//   clk, rst      global clock / synchronous active-high reset
//   pt5_mux       0: PT5 to sum term, 1: PT5 to function path
//   pt5_func_mux  1: PT5 drives OE, 0: PT5 drives async set
//   pt4_mux       0: PT4 to sum term, 1: PT4 drives async reset
//   reg_mode      2 bits per macrocell, [2i+1:2i]
//   ce            per-macrocell clock enable
//   sum_v         OR of PT1..PT3 per macrocell
//   pt5_v, pt4_v  product-term values
//   sti5_v/sti4_v steered sum-term contributions
//   oe_v          output enable (defaults to 1 when PT5 is not routed to it)
//   q_v           macrocell outputs
module pt_steer_section
  import atf_mc_pkg::*;
#(
  parameter int N_MC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_MC-1:0]   pt5_mux,
  input  logic [N_MC-1:0]   pt5_func_mux,
  input  logic [N_MC-1:0]   pt4_mux,
  input  logic [2*N_MC-1:0] reg_mode,
  input  logic [N_MC-1:0]   ce,
  input  logic [N_MC-1:0]   sum_v,
  input  logic [N_MC-1:0]   pt5_v,
  input  logic [N_MC-1:0]   pt4_v,
  output logic [N_MC-1:0]   sti5_v,
  output logic [N_MC-1:0]   sti4_v,
  output logic [N_MC-1:0]   oe_v,
  output logic [N_MC-1:0]   q_v
);

  logic [N_MC-1:0] as_v;
  logic [N_MC-1:0] ar_v;
  logic [N_MC-1:0] d_v;
  logic [N_MC-1:0] oe_sel;

  // Steering. A route that is not selected drives 0. OE is the one
  // exception: when PT5 is not routed to it, OE falls back to VCC.
  assign sti5_v = pt5_v & ~pt5_mux;
  assign sti4_v = pt4_v & ~pt4_mux;
  assign as_v   = pt5_v & pt5_mux & ~pt5_func_mux;
  assign ar_v   = pt4_v & pt4_mux;
  assign oe_sel = pt5_mux & pt5_func_mux;
  assign oe_v   = (oe_sel & pt5_v) | ~oe_sel;
  assign d_v    = sum_v | sti5_v | sti4_v;

  for (genvar i = 0; i < N_MC; i++) begin : g_mc
    mc_reg u_mc_reg (
      .clk  (clk),
      .rst  (rst),
      .ar   (ar_v[i]),
      .as   (as_v[i]),
      .ce   (ce[i]),
      .mode (reg_mode[2*i +: 2]),
      .d    (d_v[i]),
      .q    (q_v[i])
    );
  end

endmodule

// File: tb/tb_pt_steer_section.sv
// Scoreboard bench for pt_steer_section with N_MC=4. It drives directed
// vectors and pushes the hand-computed expected outputs into a queue. A
// monitor process pops each entry and compares it with the DUT outputs.
module tb_pt_steer_section;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pt5_mux, pt5_func_mux, pt4_mux, ce, sum_v, pt5_v, pt4_v;
  logic [2*N-1:0] reg_mode;
  logic [N-1:0] sti5_v, sti4_v, oe_v, q_v;

  typedef struct {
    string        name;
    logic [N-1:0] sti5;
    logic [N-1:0] sti4;
    logic [N-1:0] oe;
    logic [N-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  pt_steer_section #(.N_MC(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .pt5_mux      (pt5_mux),
    .pt5_func_mux (pt5_func_mux),
    .pt4_mux      (pt4_mux),
    .reg_mode     (reg_mode),
    .ce           (ce),
    .sum_v        (sum_v),
    .pt5_v        (pt5_v),
    .pt4_v        (pt4_v),
    .sti5_v       (sti5_v),
    .sti4_v       (sti4_v),
    .oe_v         (oe_v),
    .q_v          (q_v)
  );

  always #5 clk = ~clk;

  // Drive every data/config input. rst is driven separately.
  task automatic applyStimulus(input logic [N-1:0] p5m, input logic [N-1:0] p5f,
                               input logic [N-1:0] p4m, input logic [2*N-1:0] mode,
                               input logic [N-1:0] cen, input logic [N-1:0] sum,
                               input logic [N-1:0] p5, input logic [N-1:0] p4);
    pt5_mux = p5m; pt5_func_mux = p5f; pt4_mux = p4m; reg_mode = mode;
    ce = cen; sum_v = sum; pt5_v = p5; pt4_v = p4;
  endtask

  // Let the inputs settle, then queue an expectation and wake the monitor.
  task automatic checkOutput(input string name, input logic [N-1:0] e5,
                             input logic [N-1:0] e4, input logic [N-1:0] eoe,
                             input logic [N-1:0] eq);
    exp_t e;
    #1;
    e.name = name; e.sti5 = e5; e.sti4 = e4; e.oe = eoe; e.q = eq;
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  // Advance past the next rising edge, so that sampling stays away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s actual=%b required=%b", name, field, act, req);
    end
  endtask

  // Monitor: each time the stimulus side signals that outputs are ready, it
  // drains the queue and compares every entry.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "sti5", sti5_v, e.sti5);
        cmp(e.name, "sti4", sti4_v, e.sti4);
        cmp(e.name, "oe",   oe_v,   e.oe);
        cmp(e.name, "q",    q_v,    e.q);
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus('0, '0, '0, '0, '0, '0, '0, '0);
    step();
    checkOutput("reset", 4'b0000, 4'b0000, 4'hF, 4'b0000);

    // D mode with PT5 steered to the sum term.
    rst = 1'b0;
    applyStimulus('0, '0, '0, 8'h00, 4'hF, 4'h0, 4'b1010, 4'h0);
    checkOutput("d_comb", 4'b1010, 4'b0000, 4'hF, 4'b0000);
    step();
    checkOutput("d_reg", 4'b1010, 4'b0000, 4'hF, 4'b1010);

    // PT5 drives OE. OE follows PT5, and neither sti5 nor q sees it.
    applyStimulus(4'hF, 4'hF, '0, 8'h00, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("oe_lo", 4'b0000, 4'b0000, 4'h0, 4'b1010);
    applyStimulus(4'hF, 4'hF, '0, 8'h00, 4'hF, 4'h0, 4'hF, 4'h0);
    checkOutput("oe_hi", 4'b0000, 4'b0000, 4'hF, 4'b1010);
    step();
    checkOutput("oe_edge", 4'b0000, 4'b0000, 4'hF, 4'b0000);

    // T mode toggling, then a hold under ce=0.
    applyStimulus('0, '0, '0, 8'h55, 4'hF, 4'hF, 4'h0, 4'h0);
    checkOutput("t_pre", 4'h0, 4'h0, 4'hF, 4'h0);
    step(); checkOutput("t_1", 4'h0, 4'h0, 4'hF, 4'hF);
    step(); checkOutput("t_2", 4'h0, 4'h0, 4'hF, 4'h0);
    step(); checkOutput("t_3", 4'h0, 4'h0, 4'hF, 4'hF);
    ce = 4'h0;
    step(); checkOutput("t_hold1", 4'h0, 4'h0, 4'hF, 4'hF);
    step(); checkOutput("t_hold2", 4'h0, 4'h0, 4'hF, 4'hF);
    ce = 4'hF;
    step(); checkOutput("t_resume", 4'h0, 4'h0, 4'hF, 4'h0);

    // Load s=1 in D mode, then raise ar and as together.
    applyStimulus('0, '0, '0, 8'h00, 4'hF, 4'hF, 4'h0, 4'h0);
    step(); checkOutput("load1", 4'h0, 4'h0, 4'hF, 4'hF);
    applyStimulus(4'hF, 4'h0, 4'hF, 8'h00, 4'hF, 4'h0, 4'hF, 4'hF);
    checkOutput("aras_comb", 4'h0, 4'h0, 4'hF, 4'h0);
    step(); checkOutput("aras_edge", 4'h0, 4'h0, 4'hF, 4'h0);
    pt4_v = 4'h0;
    checkOutput("as_only", 4'h0, 4'h0, 4'hF, 4'hF);
    step();
    pt5_v = 4'h0;
    checkOutput("as_release", 4'h0, 4'h0, 4'hF, 4'hF);
    step(); checkOutput("as_gone", 4'h0, 4'h0, 4'hF, 4'h0);

    // rst in the middle of a T toggle.
    applyStimulus('0, '0, '0, 8'h55, 4'hF, 4'hF, 4'h0, 4'h0);
    step(); checkOutput("tr_1", 4'h0, 4'h0, 4'hF, 4'hF);
    step(); checkOutput("tr_2", 4'h0, 4'h0, 4'hF, 4'h0);
    step(); checkOutput("tr_3", 4'h0, 4'h0, 4'hF, 4'hF);
    rst = 1'b1;
    step(); checkOutput("tr_rst", 4'h0, 4'h0, 4'hF, 4'h0);
    rst = 1'b0;
    step(); checkOutput("tr_after", 4'h0, 4'h0, 4'hF, 4'hF);

    // Bypass mode, then a switch to D.
    applyStimulus('0, '0, '0, 8'hAA, 4'hF, 4'b0101, 4'h0, 4'h0);
    checkOutput("byp_a", 4'h0, 4'h0, 4'hF, 4'b0101);
    sum_v = 4'b0011;
    checkOutput("byp_b", 4'h0, 4'h0, 4'hF, 4'b0011);
    step();
    sum_v = 4'b1100;
    checkOutput("byp_c", 4'h0, 4'h0, 4'hF, 4'b1100);
    reg_mode = 8'h00;
    checkOutput("byp_to_d", 4'h0, 4'h0, 4'hF, 4'b0011);
    step(); checkOutput("d_after_byp", 4'h0, 4'h0, 4'hF, 4'b1100);

    // Mode 11 acts as D. After that, ce is applied per lane.
    applyStimulus('0, '0, '0, 8'hFF, 4'hF, 4'b1001, 4'h0, 4'h0);
    step(); checkOutput("mode11", 4'h0, 4'h0, 4'hF, 4'b1001);
    applyStimulus('0, '0, '0, 8'h00, 4'b0101, 4'b0110, 4'h0, 4'h0);
    step(); checkOutput("ce_lane", 4'h0, 4'h0, 4'hF, 4'b1100);

    // During reset, as on lane 0 still forces q high.
    rst = 1'b1;
    applyStimulus(4'b0001, '0, '0, 8'h00, 4'hF, 4'h0, 4'b0001, 4'h0);
    step(); checkOutput("rst_as", 4'h0, 4'h0, 4'hF, 4'b0001);
    rst = 1'b0;

    // Wait, with a bound, for the monitor to drain the queue.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
